// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder that time-shares one 4-bit ripple binary adder:
// each digit takes a binary pass (ADD) followed by a decimal-correction pass (CORR).

module bcd_adder4_rca (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar k = 0; k < 4; k++) begin : g_fa
      assign s[k]   = x[k] ^ y[k] ^ c[k];
      assign c[k+1] = (x[k] & y[k]) | (x[k] & c[k]) | (y[k] & c[k]);
   end
   assign co = c[4];
endmodule

module bcd_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                c_in,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                c_out,
   output logic                err
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, ADD, CORR, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [W-1:0]  work_q, work_d;
   logic [W-1:0]  sum_q, sum_d;
   logic [IW-1:0] i_q, i_d;
   logic [3:0]    z_q, z_d;
   logic          kz_q, kz_d;
   logic          carry_q, carry_d;
   logic          err_pend_q, err_pend_d;
   logic          c_out_q, c_out_d;
   logic          err_q, err_d;

   logic [3:0]    ad_x, ad_y, ad_s;
   logic          ad_ci, ad_co;
   logic [IW+1:0] bit_idx;
   logic          in_err;
   logic          fix;

   assign bit_idx = {i_q, 2'b00};

   bcd_adder4_rca u_adder (
      .x  (ad_x),
      .y  (ad_y),
      .ci (ad_ci),
      .s  (ad_s),
      .co (ad_co)
   );

   // Any invalid nibble on either operand at the moment of acceptance.
   always_comb begin
      in_err = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         in_err = in_err | (a[4*d +: 4] > 4'd9) | (b[4*d +: 4] > 4'd9);
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      work_d     = work_q;
      sum_d      = sum_q;
      i_d        = i_q;
      z_d        = z_q;
      kz_d       = kz_q;
      carry_d    = carry_q;
      err_pend_d = err_pend_q;
      c_out_d    = c_out_q;
      err_d      = err_q;
      ad_x       = a_q[bit_idx +: 4];
      ad_y       = b_q[bit_idx +: 4];
      ad_ci      = carry_q;
      fix        = kz_q | (z_q > 4'd9);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d        = a;
               b_d        = b;
               carry_d    = c_in;
               i_d        = '0;
               work_d     = '0;
               err_pend_d = in_err;
               state_d    = ADD;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         ADD: begin
            z_d     = ad_s;
            kz_d    = ad_co;
            state_d = CORR;
         end
         CORR: begin
            // Correction carry-out is deliberately ignored; the decimal carry is fix.
            ad_x                = z_q;
            ad_y                = fix ? 4'd6 : 4'd0;
            ad_ci               = 1'b0;
            work_d[bit_idx +: 4] = fix ? ad_s : z_q;
            carry_d             = fix;
            if (i_q == LAST_IDX) begin
               sum_d   = work_d;
               c_out_d = fix;
               err_d   = err_pend_q;
               state_d = DONE;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = ADD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         work_q     <= '0;
         sum_q      <= '0;
         i_q        <= '0;
         z_q        <= '0;
         kz_q       <= 1'b0;
         carry_q    <= 1'b0;
         err_pend_q <= 1'b0;
         c_out_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         work_q     <= work_d;
         sum_q      <= sum_d;
         i_q        <= i_d;
         z_q        <= z_d;
         kz_q       <= kz_d;
         carry_q    <= carry_d;
         err_pend_q <= err_pend_d;
         c_out_q    <= c_out_d;
         err_q      <= err_d;
      end
   end

   assign busy  = (state_q == ADD) || (state_q == CORR);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign err   = err_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl (DIGITS=4): results, latency, busy window,
// ignored mid-operation starts, back-to-back acceptance and asynchronous reset abort.

module tb_bcd_serial_adder_ctrl;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  localparam int LAT = 2 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         err;

  int n_checks;
  int n_fail;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .err   (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one start at a negedge; returns on the negedge after E0
  task automatic issue_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    @(negedge clk);
    a = av;
    b = bv;
    c_in = ci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // driver: wait for done, counting cycles since E0 and busy cycles (bounded)
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    #12;
    n_checks++;
    if ({busy, done, sum, c_out, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b err=%b, want all 0",
               busy, done, sum, c_out, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, sum} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b sum=%h, want 0 0 0000", busy, done, sum);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    issue_start(16'h1234, 16'h5678, 1'b0);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, want %0d", lat, LAT);
    end
    n_checks++;
    if (bc !== LAT) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, LAT);
    end
    n_checks++;
    if ({sum, c_out, err} !== {16'h6912, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got sum=%h c_out=%b err=%b, want 6912 0 0", sum, c_out, err);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy, sum} !== {1'b0, 1'b0, 16'h6912}) begin
      n_fail++;
      $display("FAIL done_one_cycle_hold: got done=%b busy=%b sum=%h, want 0 0 6912", done, busy, sum);
    end
  endtask

  task automatic test_ripple();
    int lat, bc;
    issue_start(16'h9999, 16'h0001, 1'b0);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== LAT || {sum, c_out, err} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ripple_9999_0001: got lat=%0d sum=%h c_out=%b err=%b, want %0d 0000 1 0",
               lat, sum, c_out, err, LAT);
    end
    issue_start(16'h9999, 16'h9999, 1'b1);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== LAT || {sum, c_out, err} !== {16'h9999, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL kz_9999_9999_c1: got lat=%0d sum=%h c_out=%b err=%b, want %0d 9999 1 0",
               lat, sum, c_out, err, LAT);
    end
  endtask

  task automatic test_invalid_digit();
    int lat, bc;
    issue_start(16'h00A0, 16'h0000, 1'b0);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== LAT || {sum, c_out, err} !== {16'h0100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL invalid_00A0: got lat=%0d sum=%h c_out=%b err=%b, want %0d 0100 0 1",
               lat, sum, c_out, err, LAT);
    end
    issue_start(16'h0003, 16'h0004, 1'b1);
    wait_done(lat, bc);
    n_checks++;
    if ({sum, c_out, err} !== {16'h0008, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_clears_cin: got sum=%h c_out=%b err=%b, want 0008 0 0", sum, c_out, err);
    end
  endtask

  task automatic test_back_to_back();
    int k, lat, bc;
    issue_start(16'h1111, 16'h2222, 1'b0);
    k = 0;
    while (!done && k < 50) begin
      if (k == 2 || k == 5) begin
        a = 16'h9999;
        b = 16'h9999;
        c_in = 1'b1;
        start = 1'b1;
      end else if (k == 7) begin
        a = 16'h0005;
        b = 16'h0007;
        c_in = 1'b0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == 3) begin
        n_checks++;
        if ({busy, sum} !== {1'b1, 16'h0008}) begin
          n_fail++;
          $display("FAIL mid_op_hold: got busy=%b sum=%h, want 1 0008", busy, sum);
        end
      end
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k !== LAT || {sum, c_out, err} !== {16'h3333, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignored_starts: got lat=%0d sum=%h c_out=%b err=%b, want %0d 3333 0 0",
               k, sum, c_out, err, LAT);
    end
    // start is still high through the DONE cycle
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 1;
    bc = 1;
    while (!done && lat < 50) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    // lat counted from the negedge after E(2D+1); one cycle already elapsed
    n_checks++;
    if (lat !== LAT + 1 || {sum, c_out} !== {16'h0012, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got cycles=%0d sum=%h c_out=%b, want %0d 0012 0",
               lat, sum, c_out, LAT + 1);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    issue_start(16'h4444, 16'h4444, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, c_out, err} !== '0) begin
      n_fail++;
      $display("FAIL async_abort: got busy=%b done=%b sum=%h c_out=%b err=%b, want all 0",
               busy, done, sum, c_out, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, sum} !== '0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: got busy=%b done=%b sum=%h, want 0 0 0000", busy, done, sum);
    end
    issue_start(16'h0005, 16'h0005, 1'b0);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== LAT || {sum, c_out, err} !== {16'h0010, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_abort: got lat=%0d sum=%h c_out=%b err=%b, want %0d 0010 0 0",
               lat, sum, c_out, err, LAT);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_invalid_digit();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end
endmodule
